// File: rtl/pid_incr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pid_incr_ctrl
// Purpose  : Time-multiplexed incremental (velocity-form) PID controller.
//            d_uk = kp*(e0-e1) + ki*e0 + kd*(e0-2*e1+e2), computed with one
//            shared multiplier over three cycles, scaled by FRAC_SH and
//            added to the held output. The clamped sum is what gets stored,
//            so the integrator cannot wind up past the output range.
// Revision : 1.0 - initial release
// ============================================================================
module pid_incr_ctrl #(
    parameter int DATA_W  = 10,
    parameter int GAIN_W  = 4,
    parameter int OUT_W   = 15,
    parameter int FRAC_SH = 0,
    parameter int OUT_MAX = 16383,
    parameter int OUT_MIN = -16384
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid_i,
    output logic                     sample_ready_o,
    input  logic signed [DATA_W-1:0] target_i,
    input  logic signed [DATA_W-1:0] y_i,
    input  logic        [GAIN_W-1:0] kp_i,
    input  logic        [GAIN_W-1:0] ki_i,
    input  logic        [GAIN_W-1:0] kd_i,
    input  logic                     clear_i,
    output logic signed [OUT_W-1:0]  uk_o,
    output logic                     out_valid_o,
    output logic                     sat_hi_o,
    output logic                     sat_lo_o,
    output logic                     drop_o
);

    // Internal widths: error, first and second differences, signed gain,
    // product and accumulator. The accumulator holds the sum of three
    // products, so two guard bits above the product width are enough.
    localparam int c_e_w    = DATA_W + 1;
    localparam int c_d1_w   = DATA_W + 2;
    localparam int c_d2_w   = DATA_W + 3;
    localparam int c_g_w    = GAIN_W + 1;
    localparam int c_prod_w = c_d2_w + c_g_w;
    localparam int c_acc_w  = DATA_W + GAIN_W + 6;
    // One bit wider than both operands so uk + increment can never wrap
    // before it is clamped.
    localparam int c_sum_w  = ((c_acc_w > OUT_W) ? c_acc_w : OUT_W) + 1;

    localparam logic signed [c_sum_w-1:0] c_max_s = c_sum_w'(OUT_MAX);
    localparam logic signed [c_sum_w-1:0] c_min_s = c_sum_w'(OUT_MIN);
    localparam logic signed [OUT_W-1:0]   c_max_o = OUT_W'(OUT_MAX);
    localparam logic signed [OUT_W-1:0]   c_min_o = OUT_W'(OUT_MIN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DIFF = 3'd1,
        S_MP   = 3'd2,
        S_MI   = 3'd3,
        S_MD   = 3'd4,
        S_UPD  = 3'd5
    } state_t;

    state_t                     state_q;
    logic signed [c_e_w-1:0]    e0_q, e1_q, e2_q;
    logic signed [c_d1_w-1:0]   d1_q;
    logic signed [c_d2_w-1:0]   d2_q;
    logic        [GAIN_W-1:0]   kp_q, ki_q, kd_q;
    logic signed [c_acc_w-1:0]  acc_q;
    logic signed [OUT_W-1:0]    uk_q;
    logic                       out_valid_q;
    logic                       sat_hi_q;
    logic                       sat_lo_q;
    logic                       drop_q;

    logic signed [c_e_w-1:0]    w_e_new;
    logic signed [c_d1_w-1:0]   w_d1;
    logic signed [c_d2_w-1:0]   w_d2;
    logic signed [c_d2_w-1:0]   w_mul_a;
    logic signed [c_g_w-1:0]    w_mul_b;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [c_acc_w-1:0]  w_acc_add;
    logic signed [c_sum_w-1:0]  w_sum;
    logic signed [OUT_W-1:0]    uk_d;
    logic                       sat_hi_d;
    logic                       sat_lo_d;
    logic                       w_drop;

    assign w_e_new = c_e_w'(target_i) - c_e_w'(y_i);
    assign w_d1    = c_d1_w'(e0_q) - c_d1_w'(e1_q);
    assign w_d2    = c_d2_w'(e0_q) - (c_d2_w'(e1_q) <<< 1) + c_d2_w'(e2_q);

    // Shared multiplier operand select: one product per state MP/MI/MD.
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (state_q)
            S_MP: begin
                w_mul_a = c_d2_w'(d1_q);
                w_mul_b = $signed({1'b0, kp_q});
            end
            S_MI: begin
                w_mul_a = c_d2_w'(e0_q);
                w_mul_b = $signed({1'b0, ki_q});
            end
            S_MD: begin
                w_mul_a = d2_q;
                w_mul_b = $signed({1'b0, kd_q});
            end
            default: begin
                w_mul_a = '0;
                w_mul_b = '0;
            end
        endcase
    end

    assign w_prod    = c_prod_w'(w_mul_a) * c_prod_w'(w_mul_b);
    assign w_acc_add = acc_q + c_acc_w'(w_prod);

    // Arithmetic shift of the signed accumulator rounds toward -infinity.
    assign w_sum = c_sum_w'(uk_q) + c_sum_w'(acc_q >>> FRAC_SH);

    // Clamp the new output and flag which side (if any) was hit.
    always_comb begin
        uk_d     = w_sum[OUT_W-1:0];
        sat_hi_d = 1'b0;
        sat_lo_d = 1'b0;
        if (w_sum > c_max_s) begin
            uk_d     = c_max_o;
            sat_hi_d = 1'b1;
        end else if (w_sum < c_min_s) begin
            uk_d     = c_min_o;
            sat_lo_d = 1'b1;
        end
    end

    assign w_drop = sample_valid_i && (state_q != S_IDLE);

    // Sequencer: accept, difference, three multiply-accumulates, update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            e0_q        <= '0;
            e1_q        <= '0;
            e2_q        <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            kp_q        <= '0;
            ki_q        <= '0;
            kd_q        <= '0;
            acc_q       <= '0;
            uk_q        <= '0;
            out_valid_q <= 1'b0;
            sat_hi_q    <= 1'b0;
            sat_lo_q    <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            drop_q      <= w_drop;
            if (clear_i) begin
                state_q  <= S_IDLE;
                e0_q     <= '0;
                e1_q     <= '0;
                e2_q     <= '0;
                d1_q     <= '0;
                d2_q     <= '0;
                acc_q    <= '0;
                uk_q     <= '0;
                sat_hi_q <= 1'b0;
                sat_lo_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (sample_valid_i) begin
                            e0_q    <= w_e_new;
                            kp_q    <= kp_i;
                            ki_q    <= ki_i;
                            kd_q    <= kd_i;
                            state_q <= S_DIFF;
                        end
                    end
                    S_DIFF: begin
                        d1_q    <= w_d1;
                        d2_q    <= w_d2;
                        state_q <= S_MP;
                    end
                    S_MP: begin
                        acc_q   <= c_acc_w'(w_prod);
                        state_q <= S_MI;
                    end
                    S_MI: begin
                        acc_q   <= w_acc_add;
                        state_q <= S_MD;
                    end
                    S_MD: begin
                        acc_q   <= w_acc_add;
                        state_q <= S_UPD;
                    end
                    S_UPD: begin
                        uk_q        <= uk_d;
                        sat_hi_q    <= sat_hi_d;
                        sat_lo_q    <= sat_lo_d;
                        out_valid_q <= 1'b1;
                        e2_q        <= e1_q;
                        e1_q        <= e0_q;
                        state_q     <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign sample_ready_o = (state_q == S_IDLE);
    assign uk_o           = uk_q;
    assign out_valid_o    = out_valid_q;
    assign sat_hi_o       = sat_hi_q;
    assign sat_lo_o       = sat_lo_q;
    assign drop_o         = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_pid_incr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pid_incr_ctrl
// Purpose  : Self-checking bench for pid_incr_ctrl. Two instances (FRAC_SH 0
//            and 2) share all inputs and are checked against an arithmetic
//            reference model of the velocity-form PID law.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pid_incr_ctrl;

    logic              clk;
    logic              rst;
    logic              valid;
    logic              clear;
    logic signed [9:0] target;
    logic signed [9:0] y;
    logic        [3:0] kp, ki, kd;

    logic              ready0, ready1;
    logic signed [14:0] uk0, uk1;
    logic              ov0, ov1, sh0, sh1, sl0, sl1, drop0, drop1;

    int checks = 0;
    int errors = 0;

    // Reference model state (shared error history, per-instance output).
    int m_e1, m_e2;
    int m_uk [2];
    int m_hi [2];
    int m_lo [2];
    int m_sh [2] = '{0, 2};

    pid_incr_ctrl #(.FRAC_SH(0)) u_dut0 (
        .clk(clk), .rst(rst), .sample_valid_i(valid), .sample_ready_o(ready0),
        .target_i(target), .y_i(y), .kp_i(kp), .ki_i(ki), .kd_i(kd),
        .clear_i(clear), .uk_o(uk0), .out_valid_o(ov0), .sat_hi_o(sh0),
        .sat_lo_o(sl0), .drop_o(drop0)
    );

    pid_incr_ctrl #(.FRAC_SH(2)) u_dut1 (
        .clk(clk), .rst(rst), .sample_valid_i(valid), .sample_ready_o(ready1),
        .target_i(target), .y_i(y), .kp_i(kp), .ki_i(ki), .kd_i(kd),
        .clear_i(clear), .uk_o(uk1), .out_valid_o(ov1), .sat_hi_o(sh1),
        .sat_lo_o(sl1), .drop_o(drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int floor_div_pow2(int v, int sh);
        int p = 1 << sh;
        int q = v / p;
        if (v < 0 && q * p != v) q = q - 1;
        return q;
    endfunction

    task automatic model_clear();
        m_e1 = 0;
        m_e2 = 0;
        for (int i = 0; i < 2; i++) begin
            m_uk[i] = 0; m_hi[i] = 0; m_lo[i] = 0;
        end
    endtask

    task automatic model_apply(int t, int yy, int gp, int gi, int gd);
        int e0, du, s;
        e0 = t - yy;
        du = gp * (e0 - m_e1) + gi * e0 + gd * (e0 - 2 * m_e1 + m_e2);
        for (int i = 0; i < 2; i++) begin
            s = m_uk[i] + floor_div_pow2(du, m_sh[i]);
            m_hi[i] = 0; m_lo[i] = 0;
            if (s > 16383) begin s = 16383; m_hi[i] = 1; end
            else if (s < -16384) begin s = -16384; m_lo[i] = 1; end
            m_uk[i] = s;
        end
        m_e2 = m_e1;
        m_e1 = e0;
    endtask

    task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(string tag);
        check({tag, "_uk0"}, uk0, m_uk[0]);
        check({tag, "_uk1"}, uk1, m_uk[1]);
        check({tag, "_hi0"}, sh0, m_hi[0]);
        check({tag, "_lo0"}, sl0, m_lo[0]);
        check({tag, "_hi1"}, sh1, m_hi[1]);
        check({tag, "_lo1"}, sl1, m_lo[1]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // Offer one sample from IDLE and wait (bounded) for its result.
    task automatic run_sample(string tag, int t, int yy, int gp, int gi, int gd);
        int lat;
        @(negedge clk);
        target = 10'(t); y = 10'(yy);
        kp = 4'(gp); ki = 4'(gi); kd = 4'(gd);
        valid = 1'b1;
        check({tag, "_ready"}, ready0, 1);
        @(posedge clk);
        #1 valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (ov0) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, lat, 5);
        check({tag, "_ov1"}, ov1, 1);
        model_apply(t, yy, gp, gi, gd);
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; clear = 1'b0;
        target = '0; y = '0; kp = '0; ki = '0; kd = '0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_uk", uk0, 0);
        check("rst_ov", ov0, 0);
        check("rst_hi", sh0, 0);
        check("rst_lo", sl0, 0);
        check("rst_drop", drop0, 0);
        check("rst_ready", ready0, 1);

        // Proportional + integral step
        run_sample("t1a", 100, 0, 2, 1, 0);
        check("t1a_lit", uk0, 300);
        run_sample("t1b", 100, 0, 2, 1, 0);
        check("t1b_lit", uk0, 400);

        // Derivative only
        do_reset();
        run_sample("t2a", 10, 0, 0, 0, 1);
        check("t2a_lit", uk0, 10);
        run_sample("t2b", 10, 0, 0, 0, 1);
        check("t2b_lit", uk0, 0);
        run_sample("t2c", 10, 0, 0, 0, 1);
        check("t2c_lit", uk0, 0);

        // Saturation and anti-windup recovery
        do_reset();
        run_sample("t3a", 511, -512, 0, 15, 0);
        check("t3a_lit", uk0, 15345);
        run_sample("t3b", 511, -512, 0, 15, 0);
        check("t3b_lit", uk0, 16383);
        check("t3b_sat", sh0, 1);
        run_sample("t3c", -512, 511, 0, 15, 0);
        check("t3c_lit", uk0, 1038);
        check("t3c_sat", sh0, 0);

        // Continuous valid: accept once per 6 cycles, drop on the other 5
        do_reset();
        @(posedge clk);
        #1;
        target = 10'sd20; y = 10'sd5; kp = 4'd1; ki = 4'd2; kd = 4'd3;
        valid = 1'b1;
        for (int i = 0; i < 36; i++) begin
            check("t4_ready", ready0, (i % 6 == 0) ? 1 : 0);
            @(posedge clk);
            #1;
            check("t4_ov", ov0, (i % 6 == 5) ? 1 : 0);
            check("t4_drop", drop0, (i % 6 != 0) ? 1 : 0);
            if (i % 6 == 5) begin
                model_apply(20, 5, 1, 2, 3);
                check_outputs("t4");
            end
        end
        valid = 1'b0;

        // Clear during MI aborts the sample and flushes history
        do_reset();
        run_sample("t5a", 100, 0, 2, 1, 0);
        check("t5a_lit", uk0, 300);
        @(negedge clk);
        target = 10'sd50; y = 10'sd0; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        model_clear();
        check("t5_uk0", uk0, 0);
        check("t5_uk1", uk1, 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("t5_noov", ov0, 0);
        end
        run_sample("t5b", 100, 0, 2, 1, 0);
        check("t5b_lit", uk0, 300);

        // Async reset during MD
        @(negedge clk);
        target = 10'sd40; y = 10'sd0; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("t6_uk", uk0, 0);
        check("t6_ready", ready0, 1);
        check("t6_ov", ov0, 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("t6_noov", ov0, 0);
        end

        // Fractional shift rounding toward -infinity
        run_sample("t6p", 7, 0, 1, 0, 0);
        check("t6p_lit", uk1, 1);
        do_reset();
        run_sample("t6n", 0, 7, 1, 0, 0);
        check("t6n_lit", uk1, -2);

        // Randomized samples with occasional clears
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
                model_clear();
            end
            run_sample("rnd",
                       int'($urandom_range(0, 1023)) - 512,
                       int'($urandom_range(0, 1023)) - 512,
                       int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
